// File: rtl/key_pkg.sv
// key_pkg
// Shared definitions for the key conditioner: repeat-FSM state encoding,
// default timing constants for a 50 MHz system clock, a reduced constant set
// that keeps simulations short, and a counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // 50 MHz defaults: 10 ms debounce, 0.5 s repeat delay, 0.12 s repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 6000000;

  // Short constants for simulation.
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_PERIOD   = 3;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel
// One key: two-flop synchroniser, debouncer and hold-to-repeat FSM.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   key_n         raw active-low button, asynchronous
//   pressed       debounced level, 1 = held
//   key_pulse     one-cycle pulse per accepted press and per auto-repeat
//   release_pulse one-cycle pulse per accepted release
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic key_pulse,
  output logic release_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_pressed;
  logic [DW-1:0] r_cnt;
  logic          w_s;

  // Synchronised key, active-high.
  assign w_s = ~r_sync2;

  // Synchroniser and debouncer. The count only advances while the sampled
  // level differs from the accepted one, so any bounce back clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (w_s == r_pressed) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_pressed <= w_s;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  rep_state_t    r_state;
  rep_state_t    w_state_next;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_next;
  logic          r_key_pulse;
  logic          w_key_pulse_next;
  logic          r_release_pulse;
  logic          w_release_pulse_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_rcnt          <= '0;
      r_key_pulse     <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_rcnt          <= w_rcnt_next;
      r_key_pulse     <= w_key_pulse_next;
      r_release_pulse <= w_release_pulse_next;
    end
  end

  // Release wins over any repeat match landing in the same cycle. In IDLE a
  // high debounced level can only mean a fresh press, since every fall
  // returns the FSM to IDLE.
  always_comb begin
    w_state_next         = r_state;
    w_rcnt_next          = r_rcnt;
    w_key_pulse_next     = 1'b0;
    w_release_pulse_next = 1'b0;
    if (r_state != IDLE && !r_pressed) begin
      w_release_pulse_next = 1'b1;
      w_state_next         = IDLE;
      w_rcnt_next          = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pressed) begin
            w_key_pulse_next = 1'b1;
            w_rcnt_next      = '0;
            w_state_next     = DELAY;
          end
        end
        DELAY: begin
          // Without auto-repeat the FSM parks here with the counter idle.
          if (REPEAT_EN != 0) begin
            if (r_rcnt == DELAY_LAST) begin
              w_key_pulse_next = 1'b1;
              w_rcnt_next      = '0;
              w_state_next     = REPEAT;
            end else begin
              w_rcnt_next = r_rcnt + RW'(1);
            end
          end
        end
        REPEAT: begin
          if (r_rcnt == PERIOD_LAST) begin
            w_key_pulse_next = 1'b1;
            w_rcnt_next      = '0;
          end else begin
            w_rcnt_next = r_rcnt + RW'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_rcnt_next  = '0;
        end
      endcase
    end
  end

  assign pressed       = r_pressed;
  assign key_pulse     = r_key_pulse;
  assign release_pulse = r_release_pulse;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
// Turns raw active-low push-buttons into clean clock-synchronous events:
// debounced levels, press/auto-repeat pulses and release pulses. Channels are
// independent copies of key_channel.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   key_n         raw buttons [NUM_KEYS], active-low, asynchronous
//   pressed       debounced levels [NUM_KEYS], 1 = held
//   key_pulse     press / auto-repeat pulses [NUM_KEYS]
//   release_pulse release pulses [NUM_KEYS]
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (REPEAT_EN)
      ) u_channel (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n[gi]),
        .pressed      (pressed[gi]),
        .key_pulse    (key_pulse[gi]),
        .release_pulse(release_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
// Directed bench for key_conditioner using the short simulation constants.
// Two instances share the stimulus: one with auto-repeat, one without.
module tb_key_conditioner;
  import key_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] key_n;
  logic [2:0] pressed, key_pulse, release_pulse;
  logic [2:0] pressed_nr, key_pulse_nr, release_pulse_nr;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .REPEAT_DELAY(SIM_REPEAT_DELAY), .REPEAT_PERIOD(SIM_REPEAT_PERIOD),
    .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .pressed(pressed), .key_pulse(key_pulse), .release_pulse(release_pulse)
  );

  key_conditioner #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .REPEAT_DELAY(SIM_REPEAT_DELAY), .REPEAT_PERIOD(SIM_REPEAT_PERIOD),
    .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .key_n(key_n),
    .pressed(pressed_nr), .key_pulse(key_pulse_nr), .release_pulse(release_pulse_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] key_n;
    logic [2:0] exp_pressed;
    logic [2:0] exp_kp;
    logic [2:0] exp_rp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [2:0] kn,
                         input logic [2:0] p, input logic [2:0] kp, input logic [2:0] rp);
    vec_t v;
    v.name = name; v.key_n = kn; v.exp_pressed = p; v.exp_kp = kp; v.exp_rp = rp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    // Clean press of key 0: low for 8 edges, then released.
    for (int k = 1; k <= 17; k++)
      add_vec($sformatf("clean[%0d]", k), (k <= 8) ? 3'b110 : 3'b111,
              (k >= 6 && k <= 13) ? 3'b001 : 3'b000,
              (k == 7) ? 3'b001 : 3'b000,
              (k == 15) ? 3'b001 : 3'b000);
    // Bounce on key 0: toggles every 2 edges for 12 edges, stable low to 22.
    for (int k = 1; k <= 32; k++) begin
      logic b;
      if (k <= 12) b = (((k - 1) / 2) % 2) != 0;
      else         b = (k > 22);
      add_vec($sformatf("bounce[%0d]", k), {2'b11, b},
              (k >= 18 && k <= 27) ? 3'b001 : 3'b000,
              (k == 19) ? 3'b001 : 3'b000,
              (k == 29) ? 3'b001 : 3'b000);
    end
    // Keys 0 and 2 together; key 1 untouched.
    for (int k = 1; k <= 17; k++)
      add_vec($sformatf("dual[%0d]", k), (k <= 8) ? 3'b010 : 3'b111,
              (k >= 6 && k <= 13) ? 3'b101 : 3'b000,
              (k == 7) ? 3'b101 : 3'b000,
              (k == 15) ? 3'b101 : 3'b000);

    // Reset state.
    rst = 1'b1;
    key_n = 3'b111;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("reset[%0d]", k),
            {pressed, key_pulse, release_pulse, pressed_nr, key_pulse_nr, release_pulse_nr}, 18'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) tick();

    // Table: both instances must agree since no scenario reaches a repeat.
    foreach (vecs[i]) begin
      key_n = vecs[i].key_n;
      tick();
      check(vecs[i].name,
            {pressed, key_pulse, release_pulse, pressed_nr, key_pulse_nr, release_pulse_nr},
            {vecs[i].exp_pressed, vecs[i].exp_kp, vecs[i].exp_rp,
             vecs[i].exp_pressed, vecs[i].exp_kp, vecs[i].exp_rp});
    end

    // Hold 40 edges. Repeat instance: pulses at 7, 17, 20, ... 44; the slot
    // at 47 coincides with the release and must be suppressed.
    for (int k = 1; k <= 50; k++) begin
      logic [2:0] e_kp, e_kp_nr, e_rp;
      key_n = (k <= 40) ? 3'b110 : 3'b111;
      tick();
      e_kp    = (k == 7 || (k >= 17 && k <= 44 && (k - 17) % 3 == 0)) ? 3'b001 : 3'b000;
      e_kp_nr = (k == 7) ? 3'b001 : 3'b000;
      e_rp    = (k == 47) ? 3'b001 : 3'b000;
      check($sformatf("hold[%0d]", k),
            {6'd0, key_pulse, key_pulse_nr, release_pulse, release_pulse_nr},
            {6'd0, e_kp, e_kp_nr, e_rp, e_rp});
    end

    // Reset while the repeat instance is in REPEAT (pulse at 23), key held.
    key_n = 3'b110;
    for (int k = 1; k <= 24; k++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid[0]",
          {pressed, key_pulse, release_pulse, pressed_nr, key_pulse_nr, release_pulse_nr}, 18'd0);
    tick();
    check("rst_mid[1]",
          {pressed, key_pulse, release_pulse, pressed_nr, key_pulse_nr, release_pulse_nr}, 18'd0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic [2:0] e_p, e_kp;
      tick();
      e_p  = (k >= 6) ? 3'b001 : 3'b000;
      e_kp = (k == 7) ? 3'b001 : 3'b000;
      check($sformatf("post_rst[%0d]", k),
            {pressed, key_pulse, release_pulse, pressed_nr, key_pulse_nr, release_pulse_nr},
            {e_p, e_kp, 3'b000, e_p, e_kp, 3'b000});
    end
    key_n = 3'b111;
    for (int k = 1; k <= 10; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
